// File: rtl/mem_access_arbiter_pkg.sv
// Shared widths and read-owner encoding for the unified memory arbiter.
package mem_access_arbiter_pkg;

    localparam int DEF_MEM_ADDR_BITS = 14;
    localparam int DEF_XLEN          = 32;
    localparam int DEF_XLEN_BYTES    = DEF_XLEN / 8;
    localparam int DEF_STARVE_LIMIT  = 4;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_OCD  = 2'd1,
        OWNER_CODE = 2'd2,
        OWNER_DATA = 2'd3
    } rd_owner_t;

endpackage

// File: rtl/mem_access_arbiter.sv
// Single-port code/data memory arbiter: OCD > starved fetch > load/store > fetch,
// with a one-cycle read-owner tag steering the returned read data.
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int MEM_ADDR_BITS = DEF_MEM_ADDR_BITS,
    parameter int XLEN          = DEF_XLEN,
    parameter int XLEN_BYTES    = DEF_XLEN_BYTES,
    parameter int STARVE_LIMIT  = DEF_STARVE_LIMIT
) (
    input  logic                     clk,
    input  logic                     sync_reset,
    input  logic                     ocd_req,
    input  logic                     ocd_we,
    input  logic [MEM_ADDR_BITS-1:0] ocd_addr,
    input  logic [XLEN-1:0]          ocd_wdata,
    output logic                     ocd_gnt,
    output logic                     ocd_rvalid,
    input  logic                     code_req,
    input  logic [MEM_ADDR_BITS-1:0] code_addr,
    output logic                     code_gnt,
    output logic                     code_rvalid,
    input  logic                     data_req,
    input  logic [XLEN_BYTES-1:0]    data_we,
    input  logic [MEM_ADDR_BITS-1:0] data_addr,
    input  logic [XLEN-1:0]          data_wdata,
    output logic                     data_gnt,
    output logic                     data_rvalid,
    output logic [XLEN-1:0]          rdata,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    output logic                     mem_read_en,
    output logic [XLEN_BYTES-1:0]    mem_write_en,
    output logic [XLEN-1:0]          mem_write_data,
    input  logic [XLEN-1:0]          mem_read_data
);

    logic [3:0] r_starve_cnt;
    rd_owner_t  r_rd_owner;

    logic       w_code_starved;
    logic       w_ocd_gnt;
    logic       w_code_gnt;
    logic       w_data_gnt;
    rd_owner_t  w_next_owner;

    assign w_code_starved = (r_starve_cnt == 4'(STARVE_LIMIT));

    // Reset suppresses every grant so no access reaches memory in that cycle.
    always_comb begin
        w_ocd_gnt  = 1'b0;
        w_code_gnt = 1'b0;
        w_data_gnt = 1'b0;
        if (!sync_reset) begin
            if (ocd_req)                          w_ocd_gnt  = 1'b1;
            else if (code_req && w_code_starved)  w_code_gnt = 1'b1;
            else if (data_req)                    w_data_gnt = 1'b1;
            else if (code_req)                    w_code_gnt = 1'b1;
        end
    end

    always_comb begin
        mem_addr       = data_addr;
        mem_write_data = data_wdata;
        mem_read_en    = 1'b0;
        mem_write_en   = '0;
        w_next_owner   = OWNER_NONE;
        if (w_ocd_gnt) begin
            mem_addr       = ocd_addr;
            mem_write_data = ocd_wdata;
            if (ocd_we) begin
                mem_write_en = '1;
            end else begin
                mem_read_en  = 1'b1;
                w_next_owner = OWNER_OCD;
            end
        end else if (w_code_gnt) begin
            mem_addr     = code_addr;
            mem_read_en  = 1'b1;
            w_next_owner = OWNER_CODE;
        end else if (w_data_gnt) begin
            if (data_we == '0) begin
                mem_read_en  = 1'b1;
                w_next_owner = OWNER_DATA;
            end else begin
                mem_write_en = data_we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_starve_cnt <= 4'd0;
            r_rd_owner   <= OWNER_NONE;
        end else begin
            r_rd_owner <= w_next_owner;
            if (code_req && !w_code_gnt) begin
                if (!w_code_starved)
                    r_starve_cnt <= r_starve_cnt + 4'd1;
            end else begin
                r_starve_cnt <= 4'd0;
            end
        end
    end

    assign ocd_gnt     = w_ocd_gnt;
    assign code_gnt    = w_code_gnt;
    assign data_gnt    = w_data_gnt;
    assign ocd_rvalid  = (r_rd_owner == OWNER_OCD);
    assign code_rvalid = (r_rd_owner == OWNER_CODE);
    assign data_rvalid = (r_rd_owner == OWNER_DATA);
    assign rdata       = mem_read_data;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed plus randomized bench for mem_access_arbiter against a cycle-level
// reference model built from the arbitration rules.
module tb_mem_access_arbiter;

    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          sync_reset;
    logic          ocd_req, ocd_we;
    logic [AW-1:0] ocd_addr;
    logic [DW-1:0] ocd_wdata;
    logic          ocd_gnt, ocd_rvalid;
    logic          code_req;
    logic [AW-1:0] code_addr;
    logic          code_gnt, code_rvalid;
    logic          data_req;
    logic [BW-1:0] data_we;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_gnt, data_rvalid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_read_en;
    logic [BW-1:0] mem_write_en;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: consecutive denied fetch cycles and which
    // requesters expect read data in the current cycle.
    int       m_starve = 0;
    bit [2:0] m_rv     = 3'b000;
    byte      dut_win;
    string    pat;

    always #5 clk = ~clk;

    mem_access_arbiter #(
        .MEM_ADDR_BITS(AW), .XLEN(DW), .XLEN_BYTES(BW), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .sync_reset(sync_reset),
        .ocd_req(ocd_req), .ocd_we(ocd_we), .ocd_addr(ocd_addr), .ocd_wdata(ocd_wdata),
        .ocd_gnt(ocd_gnt), .ocd_rvalid(ocd_rvalid),
        .code_req(code_req), .code_addr(code_addr), .code_gnt(code_gnt), .code_rvalid(code_rvalid),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .rdata(rdata), .mem_addr(mem_addr), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are already set (low clock phase); check this cycle, then advance.
    task automatic step();
        byte           win;
        bit            is_rd;
        logic [BW-1:0] exp_we;
        #1;
        if (sync_reset)                         win = "N";
        else if (ocd_req)                       win = "O";
        else if (code_req && m_starve >= LIMIT) win = "C";
        else if (data_req)                      win = "D";
        else if (code_req)                      win = "C";
        else                                    win = "N";

        is_rd  = (win == "O" && !ocd_we) || (win == "C") || (win == "D" && data_we == 0);
        exp_we = (win == "O" && ocd_we) ? 4'hF : (win == "D") ? data_we : 4'h0;

        dut_win = ocd_gnt ? "O" : code_gnt ? "C" : data_gnt ? "D" : "N";
        chk("gnt_ocd_code_data", {ocd_gnt, code_gnt, data_gnt},
            {win == "O", win == "C", win == "D"});
        chk("mem_read_en", mem_read_en, is_rd);
        chk("mem_write_en", mem_write_en, exp_we);
        if (win == "O") chk("mem_addr_ocd", mem_addr, ocd_addr);
        if (win == "C") chk("mem_addr_code", mem_addr, code_addr);
        if (win == "D") chk("mem_addr_data", mem_addr, data_addr);
        if (win == "O" && ocd_we) chk("mem_wdata_ocd", mem_write_data, ocd_wdata);
        if (win == "D" && data_we != 0) chk("mem_wdata_data", mem_write_data, data_wdata);
        chk("rvalid_ocd_code_data", {ocd_rvalid, code_rvalid, data_rvalid}, m_rv);
        if (m_rv != 0) chk("rdata", rdata, mem_read_data);

        @(posedge clk);
        m_rv = {win == "O" && is_rd, win == "C", win == "D" && is_rd};
        if (sync_reset)                   m_starve = 0;
        else if (code_req && win != "C")  m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
        else                              m_starve = 0;
        @(negedge clk);
    endtask

    initial begin
        sync_reset = 1'b1;
        ocd_req = 0; ocd_we = 0; ocd_addr = '0; ocd_wdata = '0;
        code_req = 0; code_addr = '0;
        data_req = 0; data_we = '0; data_addr = '0; data_wdata = '0;
        mem_read_data = '0;
        @(posedge clk);
        @(negedge clk);
        step();
        sync_reset = 1'b0;
        step();

        // Single fetch; memory answers 0x13 the following cycle.
        code_req = 1; code_addr = 14'h010;
        step();
        chk("single_fetch_gnt", dut_win, "C");
        code_req = 0; mem_read_data = 32'h0000_0013;
        step();
        chk("single_fetch_rdata", rdata, 32'h0000_0013);

        // Partial store beats a pending fetch; fetch follows.
        data_req = 1; data_we = 4'b0011; data_addr = 14'h020; data_wdata = 32'hDEAD_BEEF;
        code_req = 1; code_addr = 14'h044;
        step();
        data_req = 0; data_we = 4'b0000;
        step();
        chk("fetch_after_store", dut_win, "C");

        // Continuous contention: four loads then one forced fetch.
        data_req = 1; data_addr = 14'h100;
        pat = "";
        for (int i = 0; i < 10; i++) begin
            step();
            pat = $sformatf("%s%c", pat, dut_win);
        end
        n_tests++;
        assert (pat == "DDDDCDDDDC") else begin
            n_fail++;
            $error("FAIL starve_pattern: observed %s expected DDDDCDDDDC", pat);
        end

        // Starve the fetch, then let OCD reads override it.
        for (int i = 0; i < 4; i++) step();
        ocd_req = 1; ocd_we = 0; ocd_addr = 14'h3FF;
        step();
        chk("ocd_over_starved", dut_win, "O");
        step();
        ocd_req = 0;
        step();
        chk("code_after_ocd_drop", dut_win, "C");

        // OCD full-word write.
        code_req = 0; data_req = 0;
        ocd_req = 1; ocd_we = 1; ocd_wdata = 32'h1234_5678;
        step();
        ocd_req = 0; ocd_we = 0;
        step();

        // Reset lands on a granted load: nothing issues, nothing returns.
        data_req = 1; data_we = 4'b0000; data_addr = 14'h055; code_req = 1;
        sync_reset = 1;
        step();
        sync_reset = 0; data_req = 0; code_req = 0;
        step();

        for (int i = 0; i < 3000; i++) begin
            sync_reset    = ($urandom_range(0, 99) == 0);
            ocd_req       = ($urandom_range(0, 7) == 0);
            ocd_we        = $urandom_range(0, 1);
            ocd_addr      = AW'($urandom);
            ocd_wdata     = $urandom;
            code_req      = ($urandom_range(0, 3) != 0);
            code_addr     = AW'($urandom);
            data_req      = ($urandom_range(0, 3) != 0);
            data_we       = ($urandom_range(0, 1) == 0) ? 4'b0000 : BW'($urandom);
            data_addr     = AW'($urandom);
            data_wdata    = $urandom;
            mem_read_data = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
